// File: rtl/alarm_sequencer.sv
// alarm_sequencer: alarm annunciator with prescaled blink, LED patterns,
// limited snooze, dismiss and automatic ring timeout.
module alarm_sequencer #(
    parameter int unsigned LED_W         = 16,
    parameter int unsigned TICK_DIV      = 50_000_000,
    parameter int unsigned TIMEOUT_TICKS = 120,
    parameter int unsigned SNOOZE_TICKS  = 600,
    parameter int unsigned MAX_SNOOZE    = 3
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             alarmFlag,
    input  logic             ack,
    input  logic             snooze,
    input  logic [1:0]       mode,
    output logic [LED_W-1:0] led,
    output logic             active,
    output logic             snoozing
);

    localparam int unsigned DIV_W = $clog2(TICK_DIV);
    localparam int unsigned TO_W  = $clog2(TIMEOUT_TICKS + 1);
    localparam int unsigned SN_W  = $clog2(SNOOZE_TICKS + 1);
    localparam int unsigned SNZ_W = (MAX_SNOOZE == 0) ? 1 : $clog2(MAX_SNOOZE + 1);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_TICKS - 1);
    localparam logic [SN_W-1:0]  SN_LAST  = SN_W'(SNOOZE_TICKS - 1);
    localparam logic [SNZ_W-1:0] SNZ_MAX  = SNZ_W'(MAX_SNOOZE);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RING   = 2'd1,
        S_SNOOZE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t            state, state_d;
    logic [DIV_W-1:0]  div, div_d;
    logic [TO_W-1:0]   to_cnt, to_d;
    logic [SN_W-1:0]   sn_cnt, sn_d;
    logic [SNZ_W-1:0]  snz_cnt, snz_d;
    logic [1:0]        mode_q, mode_d;
    logic [LED_W-1:0]  led_d;
    logic              active_d;
    logic              snoozing_d;
    logic              tick_c;
    logic [DIV_W-1:0]  div_inc_c;

    // Pattern loaded on every entry to RING.
    function automatic logic [LED_W-1:0] init_pattern(input logic [1:0] m);
        logic [LED_W-1:0] p;
        p = '0;
        case (m)
            2'd1: begin
                for (int i = 0; i < int'(LED_W); i++) begin
                    p[i] = ((i % 2) == 0);
                end
            end
            2'd2:    p = LED_W'(1);
            default: p = '1;
        endcase
        return p;
    endfunction

    // Pattern advance applied on each tick while ringing.
    function automatic logic [LED_W-1:0] step_pattern(input logic [1:0]       m,
                                                      input logic [LED_W-1:0] cur);
        logic [LED_W-1:0] p;
        case (m)
            2'd0, 2'd1: p = ~cur;
            2'd2:       p = {cur[LED_W-2:0], cur[LED_W-1]};
            default:    p = cur;
        endcase
        return p;
    endfunction

    // Prescaler terminal count and its wrapped successor.
    assign tick_c    = (div == DIV_LAST);
    assign div_inc_c = tick_c ? '0 : div + 1'b1;

    // Next-state and next-output logic.
    always_comb begin
        state_d = state;
        div_d   = div;
        to_d    = to_cnt;
        sn_d    = sn_cnt;
        snz_d   = snz_cnt;
        mode_d  = mode_q;
        led_d   = led;

        case (state)
            S_IDLE: begin
                div_d = '0;
                led_d = '0;
                if (alarmFlag) begin
                    state_d = S_RING;
                    mode_d  = mode;
                    led_d   = init_pattern(mode);
                    to_d    = '0;
                end
            end

            S_RING: begin
                div_d = div_inc_c;
                if (ack) begin
                    state_d = S_DONE;
                    div_d   = '0;
                    led_d   = '0;
                end else if (tick_c && (to_cnt == TO_LAST)) begin
                    state_d = S_DONE;
                    div_d   = '0;
                    led_d   = '0;
                    to_d    = '0;
                end else if (snooze && (snz_cnt < SNZ_MAX)) begin
                    state_d = S_SNOOZE;
                    snz_d   = snz_cnt + 1'b1;
                    div_d   = '0;
                    sn_d    = '0;
                    led_d   = '0;
                end else if (tick_c) begin
                    led_d = step_pattern(mode_q, led);
                    to_d  = to_cnt + 1'b1;
                end
            end

            S_SNOOZE: begin
                div_d = div_inc_c;
                led_d = '0;
                if (ack) begin
                    state_d = S_DONE;
                    div_d   = '0;
                end else if (tick_c) begin
                    if (sn_cnt == SN_LAST) begin
                        state_d = S_RING;
                        sn_d    = '0;
                        to_d    = '0;
                        div_d   = '0;
                        led_d   = init_pattern(mode_q);
                    end else begin
                        sn_d = sn_cnt + 1'b1;
                    end
                end
            end

            S_DONE: begin
                div_d = '0;
                led_d = '0;
                if (!alarmFlag) begin
                    state_d = S_IDLE;
                    snz_d   = '0;
                end
            end

            default: begin
                state_d = S_IDLE;
                div_d   = '0;
                led_d   = '0;
            end
        endcase

        active_d   = (state_d == S_RING);
        snoozing_d = (state_d == S_SNOOZE);
    end

    // State, counters and registered outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= S_IDLE;
            div      <= '0;
            to_cnt   <= '0;
            sn_cnt   <= '0;
            snz_cnt  <= '0;
            mode_q   <= '0;
            led      <= '0;
            active   <= 1'b0;
            snoozing <= 1'b0;
        end else begin
            state    <= state_d;
            div      <= div_d;
            to_cnt   <= to_d;
            sn_cnt   <= sn_d;
            snz_cnt  <= snz_d;
            mode_q   <= mode_d;
            led      <= led_d;
            active   <= active_d;
            snoozing <= snoozing_d;
        end
    end

endmodule

// File: tb/tb_alarm_sequencer.sv
// tb_alarm_sequencer: directed literal checks plus randomized run against a
// cycle-count based behavioural model.
module tb_alarm_sequencer;

    localparam int T_DIV    = 4;
    localparam int T_TO     = 6;
    localparam int T_SN     = 3;
    localparam int T_MAX    = 2;
    localparam int RING_CYC = T_TO * T_DIV;
    localparam int SN_CYC   = T_SN * T_DIV;

    localparam int P_IDLE   = 0;
    localparam int P_RING   = 1;
    localparam int P_SNOOZE = 2;
    localparam int P_DONE   = 3;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       alarmFlag = 1'b0;
    logic       ack = 1'b0;
    logic       snooze = 1'b0;
    logic [1:0] mode = 2'd0;
    logic [7:0] led, led_w;
    logic       active, active_w;
    logic       snoozing, snoozing_w;

    int errors = 0;
    int checks = 0;

    alarm_sequencer #(
        .LED_W(8), .TICK_DIV(T_DIV), .TIMEOUT_TICKS(T_TO),
        .SNOOZE_TICKS(T_SN), .MAX_SNOOZE(T_MAX)
    ) dut (
        .CLK(CLK), .RST(RST), .alarmFlag(alarmFlag), .ack(ack),
        .snooze(snooze), .mode(mode), .led(led), .active(active),
        .snoozing(snoozing)
    );

    // Longer timeout so a full chase wrap is visible.
    alarm_sequencer #(
        .LED_W(8), .TICK_DIV(T_DIV), .TIMEOUT_TICKS(10),
        .SNOOZE_TICKS(T_SN), .MAX_SNOOZE(T_MAX)
    ) dut_w (
        .CLK(CLK), .RST(RST), .alarmFlag(alarmFlag), .ack(ack),
        .snooze(snooze), .mode(mode), .led(led_w), .active(active_w),
        .snoozing(snoozing_w)
    );

    always #5 CLK = ~CLK;

    // Model: phase, cycles elapsed in phase, snoozes used, latched mode.
    int m_ph   = P_IDLE;
    int m_el   = 0;
    int m_snz  = 0;
    int m_mode = 0;

    function automatic logic [7:0] mpat(input int m, input int k);
        case (m)
            0:       return (k % 2 == 0) ? 8'hFF : 8'h00;
            1:       return (k % 2 == 0) ? 8'h55 : 8'hAA;
            2:       return 8'(1 << (k % 8));
            default: return 8'hFF;
        endcase
    endfunction

    always @(posedge CLK) begin
        if (RST) begin
            m_ph  <= P_IDLE;
            m_el  <= 0;
            m_snz <= 0;
        end else begin
            case (m_ph)
                P_IDLE: if (alarmFlag) begin
                    m_ph   <= P_RING;
                    m_el   <= 0;
                    m_mode <= int'(mode);
                end
                P_RING: begin
                    if (ack || (m_el + 1 == RING_CYC)) begin
                        m_ph <= P_DONE;
                    end else if (snooze && m_snz < T_MAX) begin
                        m_ph  <= P_SNOOZE;
                        m_el  <= 0;
                        m_snz <= m_snz + 1;
                    end else begin
                        m_el <= m_el + 1;
                    end
                end
                P_SNOOZE: begin
                    if (ack) begin
                        m_ph <= P_DONE;
                    end else if (m_el + 1 == SN_CYC) begin
                        m_ph <= P_RING;
                        m_el <= 0;
                    end else begin
                        m_el <= m_el + 1;
                    end
                end
                default: if (!alarmFlag) begin
                    m_ph  <= P_IDLE;
                    m_snz <= 0;
                end
            endcase
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison of the DUT against the model.
    initial begin
        @(posedge CLK);
        forever begin
            @(negedge CLK);
            check("model_led", 32'(led),
                  (m_ph == P_RING) ? 32'(mpat(m_mode, m_el / T_DIV)) : 32'd0);
            check("model_active", 32'(active), 32'(m_ph == P_RING));
            check("model_snoozing", 32'(snoozing), 32'(m_ph == P_SNOOZE));
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic to_idle();
        ack = 1'b1;
        step(1);
        ack = 1'b0;
        alarmFlag = 1'b0;
        step(2);
    endtask

    task automatic pulse_snooze();
        snooze = 1'b1;
        step(1);
        snooze = 1'b0;
    endtask

    logic [7:0] pat2 [0:8];
    int cnt;

    initial begin
        pat2[0] = 8'h01; pat2[1] = 8'h02; pat2[2] = 8'h04;
        pat2[3] = 8'h08; pat2[4] = 8'h10; pat2[5] = 8'h20;
        pat2[6] = 8'h40; pat2[7] = 8'h80; pat2[8] = 8'h01;

        step(3);
        RST = 1'b0;
        step(1);
        check("reset_led", 32'(led), 32'h0);
        check("reset_active", 32'(active), 32'h0);
        check("reset_snoozing", 32'(snoozing), 32'h0);

        // Mode 0 blink, dismiss, retrigger only after alarmFlag drops.
        mode = 2'd0;
        alarmFlag = 1'b1;
        step(1);
        check("m0_entry", 32'(led), 32'hFF);
        check("m0_active", 32'(active), 32'h1);
        step(4);
        check("m0_tick1", 32'(led), 32'h00);
        step(4);
        check("m0_tick2", 32'(led), 32'hFF);
        ack = 1'b1;
        step(1);
        ack = 1'b0;
        check("ack_led", 32'(led), 32'h0);
        check("ack_active", 32'(active), 32'h0);
        step(5);
        check("done_hold", 32'(led), 32'h0);
        alarmFlag = 1'b0;
        step(1);
        alarmFlag = 1'b1;
        step(1);
        check("retrigger", 32'(led), 32'hFF);
        to_idle();

        // Mode 1 alternate.
        mode = 2'd1;
        alarmFlag = 1'b1;
        step(1);
        check("m1_k0", 32'(led), 32'h55);
        step(4);
        check("m1_k1", 32'(led), 32'hAA);
        step(4);
        check("m1_k2", 32'(led), 32'h55);
        to_idle();

        // Mode 2 chase with wrap; mode change mid-ring ignored.
        mode = 2'd2;
        alarmFlag = 1'b1;
        for (int k = 0; k <= 8; k++) begin
            step(k == 0 ? 1 : 4);
            check("chase_wrap", 32'(led_w), 32'(pat2[k]));
            if (k <= 5) check("chase", 32'(led), 32'(pat2[k]));
            if (k == 1) mode = 2'd0;
        end
        to_idle();

        // Timeout with no buttons.
        mode = 2'd0;
        alarmFlag = 1'b1;
        step(1);
        cnt = 0;
        while (active === 1'b1 && cnt < 40) begin
            step(1);
            cnt++;
        end
        check("timeout_len", 32'(cnt), 32'd24);
        check("timeout_led", 32'(led), 32'h0);
        step(5);
        check("timeout_hold", 32'(active), 32'h0);
        to_idle();

        // Snooze twice honoured, third ignored.
        alarmFlag = 1'b1;
        step(3);
        pulse_snooze();
        check("snz1_flag", 32'(snoozing), 32'h1);
        check("snz1_led", 32'(led), 32'h0);
        cnt = 0;
        while (snoozing === 1'b1 && cnt < 40) begin
            step(1);
            cnt++;
        end
        check("snz1_len", 32'(cnt), 32'd12);
        check("snz1_reload", 32'(led), 32'hFF);
        check("snz1_ring", 32'(active), 32'h1);
        step(2);
        pulse_snooze();
        check("snz2_flag", 32'(snoozing), 32'h1);
        cnt = 0;
        while (snoozing === 1'b1 && cnt < 40) begin
            step(1);
            cnt++;
        end
        check("snz2_len", 32'(cnt), 32'd12);
        step(2);
        pulse_snooze();
        check("snz3_ignored", 32'(snoozing), 32'h0);
        check("snz3_ring", 32'(active), 32'h1);
        to_idle();

        // ack and snooze together.
        alarmFlag = 1'b1;
        step(2);
        ack = 1'b1;
        snooze = 1'b1;
        step(1);
        ack = 1'b0;
        snooze = 1'b0;
        check("ack_snz_active", 32'(active), 32'h0);
        check("ack_snz_snoozing", 32'(snoozing), 32'h0);
        to_idle();

        // Timeout tick coinciding with snooze.
        alarmFlag = 1'b1;
        step(1);
        step(23);
        pulse_snooze();
        check("to_snz_active", 32'(active), 32'h0);
        check("to_snz_snoozing", 32'(snoozing), 32'h0);
        to_idle();

        // Reset mid-RING after using both snoozes, then mid-SNOOZE.
        alarmFlag = 1'b1;
        step(1);
        pulse_snooze();
        step(12);
        pulse_snooze();
        step(12);
        step(2);
        RST = 1'b1;
        step(1);
        RST = 1'b0;
        check("rst_ring_led", 32'(led), 32'h0);
        check("rst_ring_active", 32'(active), 32'h0);
        check("rst_ring_snoozing", 32'(snoozing), 32'h0);
        step(1);
        pulse_snooze();
        check("rst_snz_cleared1", 32'(snoozing), 32'h1);
        step(12);
        pulse_snooze();
        check("rst_snz_cleared2", 32'(snoozing), 32'h1);
        step(3);
        RST = 1'b1;
        step(1);
        RST = 1'b0;
        check("rst_snz_led", 32'(led), 32'h0);
        check("rst_snz_active", 32'(active), 32'h0);
        check("rst_snz_snoozing", 32'(snoozing), 32'h0);
        to_idle();

        // Randomized traffic checked every cycle by the model.
        for (int c = 0; c < 3000; c++) begin
            RST    = ($urandom_range(0, 399) == 0);
            if ($urandom_range(0, 29) == 0) alarmFlag = ~alarmFlag;
            ack    = ($urandom_range(0, 59) == 0);
            snooze = ($urandom_range(0, 7) == 0);
            mode   = 2'($urandom_range(0, 3));
            step(1);
        end
        RST = 1'b0;
        ack = 1'b0;
        snooze = 1'b0;
        step(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alarm_sequencer.md
# alarm_sequencer

Parametrised alarm annunciator for the digital clock. It sits between the time/alarm comparator, which drives `alarmFlag`, and the board LEDs. It generalises the simple per-clock LED toggle in four ways: a prescaled blink rate, selectable LED patterns, snooze with a limit, and dismiss with an automatic ring timeout. A dismissed alarm stays silent until `alarmFlag` drops, so a still-matching comparator cannot retrigger it.

## Interface
Parameters:
- `LED_W`, 16: LED bus width, ≥2.
- `TICK_DIV`, 50_000_000: clock cycles per pattern step, ≥2 (0.5 s at 100 MHz).
- `TIMEOUT_TICKS`, 120: ticks of ringing before auto-dismiss, ≥1.
- `SNOOZE_TICKS`, 600: ticks of silence per snooze, ≥1.
- `MAX_SNOOZE`, 3: snoozes honoured per alarm event, ≥0.

Ports (one clock; reset is synchronous and active-high):
- `CLK` in 1: system clock.
- `RST` in 1: synchronous active-high reset.
- `alarmFlag` in 1: level, high while the alarm time matches.
- `ack` in 1: single-cycle dismiss pulse (debounced button).
- `snooze` in 1: single-cycle snooze pulse (debounced button).
- `mode` in 2: pattern select. 0 = all blink, 1 = alternate, 2 = chase, 3 = steady on.
- `led` out LED_W: LED drive, registered.
- `active` out 1: high in RING.
- `snoozing` out 1: high in SNOOZE.

## Operation
- FSM states: IDLE, RING, SNOOZE, DONE. Reset state is IDLE.
- IDLE → RING when `alarmFlag`=1. On entry, `mode` is latched into `mode_q`, `led` is loaded with the initial pattern, and the divider and timeout counter are cleared.
- RING → DONE on `ack`, or when the timeout counter reaches TIMEOUT_TICKS on a tick.
- RING → SNOOZE on `snooze` if `snz_cnt` < MAX_SNOOZE. The transition increments `snz_cnt`. If `snz_cnt` = MAX_SNOOZE, `snooze` is ignored.
- Priority in a single cycle: `ack` > timeout > `snooze`.
- SNOOZE → RING after SNOOZE_TICKS ticks. Re-entry reloads the initial pattern and clears the timeout counter. `alarmFlag` is ignored in SNOOZE.
- SNOOZE → DONE on `ack`.
- DONE → IDLE when `alarmFlag`=0. This transition clears `snz_cnt`.
- Divider: counts 0..TICK_DIV-1 in RING and SNOOZE, and wraps. `tick` is high when the divider = TICK_DIV-1. The divider is held at 0 in IDLE and DONE and on every entry to RING or SNOOZE.
- Initial patterns:
  - mode 0: all ones.
  - mode 1: ...0101, bit0 = 1.
  - mode 2: one-hot bit0.
  - mode 3: all ones.
- Per tick in RING:
  - modes 0 and 1: `led` <= ~`led`.
  - mode 2: rotate left by 1, MSB wraps to bit0.
  - mode 3: hold.
- `led` is 0 in IDLE, SNOOZE and DONE. Mid-ring changes to `mode` have no effect until the next entry to RING.
- Counter widths: $clog2 of (max value + 1). All counters are unsigned with no overflow; each compares for equality and then clears.

## Timing
- Reset values: `led`=0, `active`=0, `snoozing`=0, all counters 0, state IDLE.
- `RST` mid-operation returns the block to reset values on the next edge, regardless of state.
- `alarmFlag` sampled high at edge t: `active`=1 and `led` = initial pattern visible after edge t.
- First pattern change occurs TICK_DIV cycles after RING entry. Subsequent changes follow every TICK_DIV cycles.
- `ack` or `snooze` sampled at edge t: `led`=0 and the new status flag is visible after edge t (latency 1).
- Timeout: with no inputs, RING lasts exactly TIMEOUT_TICKS×TICK_DIV cycles.
- SNOOZE lasts exactly SNOOZE_TICKS×TICK_DIV cycles.
- `ack` and `snooze` pulses are level-sampled. A pulse held for multiple cycles acts on the first cycle only in effect, because the state has already changed.

## Test plan
All scenarios use LED_W=8, TICK_DIV=4, TIMEOUT_TICKS=6, SNOOZE_TICKS=3, MAX_SNOOZE=2.
- Reset, then mode 0 with `alarmFlag`=1: `led`=0xFF in the cycle after. Then 0x00 four cycles later, 0xFF eight cycles later. Pulse `ack`: `led`=0 next cycle and stays 0 while `alarmFlag`=1. Drop and then raise `alarmFlag`: ringing resumes with 0xFF.
- Mode 2: `led` steps 0x01, 0x02, …, 0x80, then 0x01, every 4 cycles (wrap check). Mode 1 alternates 0x55 and 0xAA. Changing `mode` mid-ring leaves the pattern unchanged.
- Timeout: no `ack`. `active` falls exactly 24 cycles after entry, `led`=0, and the block holds DONE until `alarmFlag`=0.
- Snooze: the pulse gives `led`=0 and `snoozing`=1 for 12 cycles, then RING with the reloaded initial pattern and a fresh 24-cycle timeout. The second snooze is honoured; the third is ignored and the block keeps ringing.
- `ack` and `snooze` in the same cycle → DONE. Timeout tick and `snooze` in the same cycle → DONE. `RST` mid-RING and mid-SNOOZE → all outputs 0 the next cycle and `snz_cnt` cleared.
